// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit path.
// FSM state enum, error codes, keyboard command bytes, frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // {odd parity, data}; shifted out LSB first
  function automatic logic [8:0] make_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_filter.sv
// ps2_line_filter: 2-FF synchronizer, glitch filter and fall detector.
// Ports: clk, rst, line_in (raw pin) -> level (filtered), fall (1-cycle pulse).
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Idle bus level is high, so everything resets to 1 to avoid a
  // spurious fall right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      fall    <= 1'b0;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
      fall    <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        level <= sync_q2;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter, open-drain via oe.
// Ports: send/tx_byte in; ps2_*_in raw pins; ps2_*_oe, busy, done, err, err_code out.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 65_000_000,
  parameter int INHIBIT_US    = 100,
  parameter int TIMEOUT_US    = 15000,
  parameter int FILTER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_lvl;
  logic clk_fall;
  logic data_lvl;
  logic unused_data_fall;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .line_in(ps2_clk_in),
    .level  (clk_lvl),
    .fall   (clk_fall)
  );

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_data_filt (
    .clk    (clk),
    .rst    (rst),
    .line_in(ps2_data_in),
    .level  (data_lvl),
    .fall   (unused_data_fall)
  );

  ps2_state_t    state, state_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] wd_cnt, wd_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [8:0]    frame, frame_n;
  logic          data_oe_n;
  logic          clk_oe_n;
  logic          busy_n;
  logic          done_n;
  logic          err_n;
  logic [1:0]    code_n;
  logic          wd_hit;

  assign wd_hit = (wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_n;
      wd_cnt      <= wd_n;
      bit_cnt     <= bit_n;
      frame       <= frame_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      err_code    <= code_n;
    end
  end

  always_comb begin
    state_n   = state;
    inh_n     = inh_cnt;
    wd_n      = wd_cnt;
    bit_n     = bit_cnt;
    frame_n   = frame;
    data_oe_n = ps2_data_oe;
    code_n    = err_code;

    unique case (state)
      IDLE: begin
        data_oe_n = 1'b0;
        if (send) begin
          state_n = INHIBIT;
          frame_n = make_frame(tx_byte);
          bit_n   = '0;
          inh_n   = '0;
          code_n  = ERR_NONE;
        end
      end
      INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
          state_n   = RTS;
          data_oe_n = 1'b1;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        // data stays low into SHIFT: that is the start bit
        state_n = SHIFT;
        wd_n    = '0;
      end
      SHIFT: begin
        if (clk_fall) begin
          wd_n  = '0;
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end else begin
            data_oe_n = ~frame[0];
            frame_n   = {1'b1, frame[8:1]};
          end
        end else if (wd_hit) begin
          state_n = ERROR;
          code_n  = ERR_TIMEOUT;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          wd_n = '0;
          if (data_lvl) begin
            state_n = ERROR;
            code_n  = ERR_NOACK;
          end else begin
            state_n = WAIT_IDLE;
          end
        end else if (wd_hit) begin
          state_n = ERROR;
          code_n  = ERR_TIMEOUT;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          state_n = DONE;
        end else if (clk_fall) begin
          wd_n = '0;
        end else if (wd_hit) begin
          state_n = ERROR;
          code_n  = ERR_TIMEOUT;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == ERROR) begin
      data_oe_n = 1'b0;
    end

    // outputs are registered from the next state
    clk_oe_n = (state_n == INHIBIT) || (state_n == RTS);
    busy_n   = !(state_n inside {IDLE, DONE, ERROR});
    done_n   = (state_n == DONE);
    err_n    = (state_n == ERROR);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device BFM plus event-timeline model of the PS/2 host tx.
// Scaled to 1 cycle/us so the watchdog case stays short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int TO   = 2000;
  localparam int FILT = 4;
  localparam int HALF = 20;
  localparam int LAT  = FILT + 3;

  logic       clk;
  logic       rst;
  logic       send;
  logic [7:0] tx_byte;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  // open-drain wires: low if either side pulls
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ  (1_000_000),
    .INHIBIT_US   (100),
    .TIMEOUT_US   (2000),
    .FILTER_CYCLES(FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .send       (send),
    .tx_byte    (tx_byte),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected-value timeline: sig 0 clk_oe,1 data_oe,2 busy,3 done,4 err,5 err_code
  typedef struct {
    int         t;
    int         sig;
    logic [1:0] v;
  } ev_t;

  ev_t        evq[$];
  ev_t        keep[$];
  logic [1:0] ex[6];

  int   checks    = 0;
  int   errors    = 0;
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   run       = 0;
  int   last_run  = 0;
  int   t_clkfall = 0;
  int   t_err     = 0;
  logic prev_clk_oe = 1'b0;

  function automatic void chk(string n, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", n, cyc, act, want);
    end
  endfunction

  function automatic void sched(int t, int sig, logic [1:0] v);
    ev_t e;
    e.t   = t;
    e.sig = sig;
    e.v   = v;
    evq.push_back(e);
  endfunction

  always @(negedge clk) begin
    keep = {};
    foreach (evq[i]) begin
      if (evq[i].t <= cyc) ex[evq[i].sig] = evq[i].v;
      else keep.push_back(evq[i]);
    end
    evq = keep;
    chk("clk_oe",   int'(ps2_clk_oe),  int'(ex[0]));
    chk("data_oe",  int'(ps2_data_oe), int'(ex[1]));
    chk("busy",     int'(busy),        int'(ex[2]));
    chk("done",     int'(done),        int'(ex[3]));
    chk("err",      int'(err),         int'(ex[4]));
    chk("err_code", int'(err_code),    int'(ex[5]));
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      t_err = cyc;
    end
    if (prev_clk_oe && !ps2_clk_oe) t_clkfall = cyc;
    if (ps2_clk_oe) run++;
    else if (run != 0) begin
      last_run = run;
      run      = 0;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_send(input logic [7:0] b, input bit stall);
    int c;
    int t;
    send    = 1'b1;
    tx_byte = b;
    c       = cyc;
    sched(c + 1, 2, 2'd1);
    sched(c + 1, 0, 2'd1);
    sched(c + 1, 5, 2'd0);
    sched(c + 1 + INH, 1, 2'd1);
    sched(c + 2 + INH, 0, 2'd0);
    if (stall) begin
      t = c + 2 + INH + TO;
      sched(t, 4, 2'd1);
      sched(t + 1, 4, 2'd0);
      sched(t, 2, 2'd0);
      sched(t, 1, 2'd0);
      sched(t, 5, 2'b01);
    end
    wait_cyc(1);
    send = 1'b0;
  endtask

  // device side: clocks nfalls edges, samples the wire on each rising edge
  task automatic run_frame(input logic [7:0] b, input int nfalls,
                           input bit ack, input bit poke,
                           output logic [9:0] seen);
    logic [8:0] fr;
    int k;
    fr   = {~^b, b};
    seen = '0;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      k = cyc;
      if (i <= 9) sched(k + LAT, 1, {1'b0, ~fr[i-1]});
      else if (i == 10) sched(k + LAT, 1, 2'd0);
      else if (!ack) begin
        sched(k + LAT, 4, 2'd1);
        sched(k + LAT + 1, 4, 2'd0);
        sched(k + LAT, 2, 2'd0);
        sched(k + LAT, 5, 2'b10);
      end
      if (poke && i == 3) begin
        wait_cyc(5);
        send    = 1'b1;
        tx_byte = CMD_RESET;
        wait_cyc(1);
        send = 1'b0;
        wait_cyc(HALF - 6);
      end else begin
        wait_cyc(HALF);
      end
      dev_clk_low = 1'b0;
      if (i <= 10) seen[i-1] = ps2_data_in;
      if (i == 10 && ack) dev_data_low = 1'b1;
      wait_cyc(HALF);
    end
    if (ack && nfalls == 11) begin
      dev_data_low = 1'b0;
      k = cyc;
      sched(k + LAT, 3, 2'd1);
      sched(k + LAT + 1, 3, 2'd0);
      sched(k + LAT, 2, 2'd0);
    end
    wait_cyc(LAT + 5);
  endtask

  initial begin
    logic [9:0] seen;
    int d0;
    int e0;
    foreach (ex[i]) ex[i] = '0;
    rst          = 1'b1;
    send         = 1'b0;
    tx_byte      = '0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    chk("reset_busy", int'(busy), 0);

    // 0xF4 with ACK
    d0 = done_cnt;
    do_send(CMD_ENABLE, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_ENABLE, 11, 1'b1, 1'b0, seen);
    chk("f4_wire", int'(seen), int'(10'b1011110100));
    chk("f4_clk_low_len", last_run, 101);
    chk("f4_done_count", done_cnt - d0, 1);
    chk("f4_err_code", int'(err_code), 0);

    // 0xED with ACK
    d0 = done_cnt;
    do_send(CMD_SET_LED, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_SET_LED, 11, 1'b1, 1'b0, seen);
    chk("ed_wire", int'(seen), int'(10'b1111101101));
    chk("ed_done_count", done_cnt - d0, 1);

    // no ACK at fall 11
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(CMD_RESET, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_RESET, 11, 1'b0, 1'b0, seen);
    chk("noack_wire", int'(seen), int'(10'b1111111111));
    chk("noack_err_count", err_cnt - e0, 1);
    chk("noack_done_count", done_cnt - d0, 0);
    chk("noack_err_code", int'(err_code), 2);

    // device never clocks
    e0 = err_cnt;
    do_send(CMD_ENABLE, 1'b1);
    wait_cyc(INH + TO + 10);
    chk("timeout_latency", t_err - t_clkfall, 2000);
    chk("timeout_err_code", int'(err_code), 1);
    chk("timeout_err_count", err_cnt - e0, 1);

    // second send during SHIFT is dropped
    d0 = done_cnt;
    do_send(CMD_SET_LED, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_SET_LED, 11, 1'b1, 1'b1, seen);
    chk("overlap_wire", int'(seen), int'(10'b1111101101));
    chk("overlap_done_count", done_cnt - d0, 1);

    // reset between fall 4 and fall 5
    do_send(CMD_ENABLE, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_ENABLE, 4, 1'b0, 1'b0, seen);
    chk("pre_rst_data_oe", int'(ps2_data_oe), 1);
    #2;
    rst = 1'b1;
    evq.delete();
    foreach (ex[i]) ex[i] = '0;
    #1;
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_busy", int'(busy), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);
    d0 = done_cnt;
    do_send(CMD_SET_LED, 1'b0);
    wait_cyc(INH + 12);
    run_frame(CMD_SET_LED, 11, 1'b1, 1'b0, seen);
    chk("after_rst_wire", int'(seen), int'(10'b1111101101));
    chk("after_rst_done_count", done_cnt - d0, 1);
    chk("after_rst_err_code", int'(err_code), 0);

    wait_cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2Clk/PS2Data pins the keyboard receive path listens on. It runs in the 65 MHz `clk65mhz` domain inside `keyboard_top`. It drives the lines open-drain through output enables, so the existing receiver is not touched. The keyboard command sequencer sits upstream and hands it bytes.

## Interface
- `CLK_FREQ_HZ`, default 65_000_000: `clk` frequency.
- `INHIBIT_US`, default 100: time the host holds the clock low before request-to-send.
- `TIMEOUT_US`, default 15000: watchdog limit between consecutive device clock falling edges.
- `FILTER_CYCLES`, default 8: number of consecutive equal samples needed to accept a PS/2 line level.
- `clk` in 1: system clock, 65 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `send` in 1: one-cycle start strobe. Ignored while `busy`.
- `tx_byte` in 8: command byte. Sampled on the cycle `send` is accepted.
- `ps2_clk_in` in 1: raw PS2Clk pin level.
- `ps2_data_in` in 1: raw PS2Data pin level.
- `ps2_clk_oe` out 1: 1 pulls PS2Clk low. 0 releases it.
- `ps2_data_oe` out 1: 1 pulls PS2Data low. 0 releases it.
- `busy` out 1: high from the accepted `send` until the `done` or `err` cycle.
- `done` out 1: one-cycle pulse when the device acknowledges and the bus returns to idle.
- `err` out 1: one-cycle pulse when a transfer is aborted.
- `err_code` out 2: 01 = timeout, 10 = no ACK. Held until the next `send`.

## Operation
- Raw line inputs pass through a 2-FF synchronizer and then a glitch filter. The filtered level changes only after `FILTER_CYCLES` consecutive equal synchronized samples. `fall` is a one-cycle pulse on a filtered clock 1→0 transition.
- Derived constant: INHIBIT_CYC = CLK_FREQ_HZ/1_000_000 × INHIBIT_US (6500 at default).
- Derived constant: TIMEOUT_CYC = CLK_FREQ_HZ/1_000_000 × TIMEOUT_US (975_000 at default, 20-bit counter).
- Frame: shift register = {odd parity, tx_byte}. Parity = ~^tx_byte.
- IDLE: all outputs 0. On `send`: latch the frame, clear the bit counter and `err_code`, go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYC cycles, then go to RTS.
- RTS: `ps2_data_oe`=1 and `ps2_clk_oe` still 1 for exactly one cycle, then go to SHIFT with `ps2_clk_oe`=0. The watchdog starts.
- SHIFT: on each `fall`, drive the next frame bit, LSB first. A bit of 0 sets `ps2_data_oe`=1; a bit of 1 sets it to 0. Falls 1–8 carry data bits 0–7. Fall 9 carries parity. On fall 10, release data (stop bit) and go to ACK.
- ACK: on the next `fall` (fall 11), sample filtered data. Data 0 goes to WAIT_IDLE. Data 1 goes to ERROR with code 10.
- WAIT_IDLE: when filtered clock and data are both 1, go to DONE.
- DONE: pulse `done`, return to IDLE.
- ERROR: pulse `err`, force both oe to 0, return to IDLE.
- Watchdog: counts in SHIFT, ACK and WAIT_IDLE. It clears on every `fall`. Reaching TIMEOUT_CYC goes to ERROR with code 01.
- Boundary behaviour:
  - `send` while `busy`: dropped, with no effect on the frame in progress.
  - `send` in the DONE/ERROR cycle: dropped. It is accepted only in IDLE.
  - Reset at any point: both oe fall to 0 asynchronously, so the lines are released immediately. The state returns to IDLE and all counters clear.
  - Device pulling data low during SHIFT does not affect the transfer.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00.
- `send` at cycle N: `busy` and `ps2_clk_oe` are 1 at N+1.
- `ps2_data_oe` rises at N+1+INHIBIT_CYC. `ps2_clk_oe` falls one cycle later.
- Input-to-`fall` latency: 2 (sync) + FILTER_CYCLES cycles after the raw pin edge. `ps2_data_oe` updates in the cycle after `fall`.
- `done`/`err` are registered. `busy` drops in the same cycle `done`/`err` is high.

## Structure
- Package `ps2_pkg`:
  - state enum {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERROR}
  - err_code constants ERR_NONE, ERR_TIMEOUT, ERR_NOACK
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF
- Sub-module `ps2_line_filter` (synchronizer + glitch filter + fall detect), instantiated once per line.
- All outputs registered. Top-level tristate drives `PS2Clk`/`PS2Data` low when the corresponding oe is 1.

## Test plan
- Send 0xF4 with a BFM device clocking at 12.5 kHz and ACKing. Expect:
  - `ps2_clk_oe` high for 6500 cycles, then RTS.
  - Data sampled on rising edges reads 0,0,1,0,1,1,1,1, then parity 0, then stop 1.
  - `done`=1 once, `err_code`=00.
- Send 0xED with ACK. Expect the bits on the wire to be 1,0,1,1,0,1,1,1, parity 1, and `done` pulses.
- BFM clocks all 11 edges but leaves data high at fall 11. Expect `err` pulse, `err_code`=10, both oe 0, and no `done`.
- BFM never clocks after RTS. Expect `err` exactly 975_000 cycles after `ps2_clk_oe` falls, `err_code`=01, and lines released.
- Second `send` of 0xFF during SHIFT. Expect it ignored: the wire carries the first byte and there is exactly one `done`.
- Assert `rst` between fall 4 and fall 5. Expect both oe to go to 0 in the same cycle and `busy`=0. A following `send` of 0xED completes normally.
